counter_10_div: RTL and testbench
=================================

Name: counter_10_div

Overview:
- Selectable clock divider driving a synchronous decade (0-9) counter with parallel load and a 7-segment display output.
- contral picks one of four division ratios of CLK to produce o_CLK.
- The counter advances once per o_CLK period.
- The count is shown on oQ (binary) and odisplay (active-low 7-segment pattern).
- Sits between a board clock/switch inputs and a single 7-segment digit.

Parameters:
- HALF0, 1, o_CLK half-period in CLK cycles when contral=00
- HALF1, 5, half-period when contral=01
- HALF2, 50, half-period when contral=10
- HALF3, 500, half-period when contral=11
- PW, 16, prescaler width; must hold max(HALFn)-1

Ports:
- CLK  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- contral  input  2  division-ratio select
- load_enable  input  1  synchronous parallel-load strobe, active high
- load_counter  input  4  value to load
- oQ  output  4  current count, binary 0-9
- odisplay  output  7  active-low segments {g,f,e,d,c,b,a}; odisplay[0]=a
- o_CLK  output  1  divided clock, registered square wave

Behaviour:
- Reset is asynchronous, active-low: while rst_n=0, prescaler=0, o_CLK=0, oQ=0, and odisplay=7'b1000000 (digit 0).
- Prescaler and o_CLK:
  - Let H = HALF[contral], sampled every cycle.
  - If prescaler >= H-1: prescaler <= 0 and o_CLK <= ~o_CLK. Otherwise prescaler <= prescaler+1.
  - o_CLK period is therefore 2*H CLK cycles at 50% duty.
  - The ">=" compare guarantees a toggle on the next cycle if contral is lowered mid-count; no glitch and no stall.
- Count tick:
  - tick = 1 in the CLK cycle where o_CLK is registered 0->1, i.e. prescaler wraps while o_CLK=0.
  - The counter is clocked by CLK only; o_CLK is never used as a clock.
- Counter, priority load > tick > hold:
  - load_enable=1: oQ <= load_counter if load_counter <= 9, else oQ <= 0. Load applies in any cycle, independent of tick; the prescaler is unaffected.
  - Otherwise, on tick: oQ <= (oQ==9) ? 0 : oQ+1.
  - Otherwise oQ holds.
  - If load and tick coincide, the load wins and the tick is lost.
  - While load_enable is held high, oQ tracks load_counter every cycle.
- odisplay is combinational from oQ, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other code = 1111111 (blank; unreachable in normal operation).
- Reset may assert at any time; release takes effect on the first CLK edge after rst_n rises.

Decomposition:
- Shared package counter_10_pkg:
  - the ten segment constants and SEG_BLANK
  - default HALF0..HALF3 localparams
  - MAX_DIGIT=9
- One sub-module, seg7_decoder: 4-bit binary in, 7-bit active-low segments out, purely combinational.
- Prescaler and decade counter stay in the top module.

Test Plan:
- Reset: hold rst_n=0 mid-count with oQ=5 -> oQ=0, o_CLK=0, odisplay=1000000 immediately and asynchronously. After release with contral=00, o_CLK toggles every CLK and oQ counts 1,2,... on every second CLK edge.
- Load: contral=00, load_enable=1, load_counter=1 for 5 cycles -> oQ=1, odisplay=1111001 throughout. After deassert, oQ steps 2,3,... once per o_CLK rising edge. load_counter=12 -> oQ=0.
- Wrap: from oQ=7, let it count -> sequence 8,9,0,1. odisplay matches each digit's table value.
- Division ratios: contral=01/10/11 -> o_CLK period 10/100/1000 CLK cycles at 50% duty, with oQ incrementing exactly once per period. Measure over at least 3 periods each.
- Ratio switch: at prescaler=40 with contral=10, switch to 01 -> o_CLK toggles on the next edge, then every 5 cycles; no missed or double counts beyond that one early toggle.
- Load/tick collision: assert load_enable=1 with load_counter=4 in the tick cycle -> oQ=4, not 5. The next tick gives 5.

Source files
------------

// File: rtl/counter_10_pkg.sv
// Shared constants for the decade counter / divider block.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package counter_10_pkg;

  typedef logic [6:0] seg_t;

  typedef enum logic [1:0] {
    DIV_SEL0 = 2'd0,
    DIV_SEL1 = 2'd1,
    DIV_SEL2 = 2'd2,
    DIV_SEL3 = 2'd3
  } div_sel_e;

  localparam int DEF_HALF0 = 1;
  localparam int DEF_HALF1 = 5;
  localparam int DEF_HALF2 = 50;
  localparam int DEF_HALF3 = 500;

  localparam int MAX_DIGIT = 9;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/counter_10_div_seg7.sv
// Binary digit to active-low 7-segment pattern.
// Codes above 9 blank the digit.
module seg7_decoder
  import counter_10_pkg::*;
(
  input  logic [3:0] bin,
  output seg_t       seg
);

  // Pure lookup; no state.
  always_comb begin
    seg = SEG_BLANK;
    unique case (bin)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/counter_10_div.sv
// Selectable clock divider feeding a loadable decade counter
// with a 7-segment readout. Everything runs on CLK.
module counter_10_div
  import counter_10_pkg::*;
#(
  parameter int HALF0 = DEF_HALF0,
  parameter int HALF1 = DEF_HALF1,
  parameter int HALF2 = DEF_HALF2,
  parameter int HALF3 = DEF_HALF3,
  parameter int PW    = 16
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic [1:0] contral,
  input  logic       load_enable,
  input  logic [3:0] load_counter,
  output logic [3:0] oQ,
  output logic [6:0] odisplay,
  output logic       o_CLK
);

  logic [PW-1:0] presc;
  logic [PW-1:0] half;
  logic [PW-1:0] half_m1;
  logic          wrap;
  logic          tick;
  logic [3:0]    load_val;
  logic [3:0]    next_up;

  // Half-period for the currently selected ratio.
  always_comb begin
    half = PW'(HALF0);
    unique case (div_sel_e'(contral))
      DIV_SEL0: half = PW'(HALF0);
      DIV_SEL1: half = PW'(HALF1);
      DIV_SEL2: half = PW'(HALF2);
      DIV_SEL3: half = PW'(HALF3);
      default:  half = PW'(HALF0);
    endcase
  end

  // Wrap uses >= so a lowered ratio toggles on the next edge.
  assign half_m1  = half - PW'(1);
  assign wrap     = presc >= half_m1;
  assign tick     = wrap & ~o_CLK;

  assign load_val = (load_counter <= 4'(MAX_DIGIT)) ?
                    load_counter : 4'd0;
  assign next_up  = (oQ == 4'(MAX_DIGIT)) ?
                    4'd0 : oQ + 4'd1;

  // Prescaler and registered divided clock.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      o_CLK <= 1'b0;
    end else if (wrap) begin
      presc <= '0;
      o_CLK <= ~o_CLK;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Decade counter: load beats tick beats hold.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      oQ <= 4'd0;
    end else if (load_enable) begin
      oQ <= load_val;
    end else if (tick) begin
      oQ <= next_up;
    end
  end

  seg7_decoder u_seg (
    .bin (oQ),
    .seg (odisplay)
  );

endmodule

// File: tb/tb_counter_10_div.sv
// Randomised and directed checks of counter_10_div
// against a cycle-level behavioural model.
module tb_counter_10_div;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] contral = 2'd0;
  logic       load_enable = 1'b0;
  logic [3:0] load_counter = 4'd0;
  logic [3:0] oQ;
  logic [6:0] odisplay;
  logic       o_CLK;

  int passed = 0;
  int total  = 0;

  int half_tab [4] = '{1, 5, 50, 500};
  logic [6:0] seg_tab [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000
  };

  // Model: cycles spent in current o_CLK phase, level, digit.
  int m_elapsed = 0;
  bit m_clk = 1'b0;
  int m_q = 0;

  counter_10_div dut (
    .CLK          (clk),
    .rst_n        (rst_n),
    .contral      (contral),
    .load_enable  (load_enable),
    .load_counter (load_counter),
    .oQ           (oQ),
    .odisplay     (odisplay),
    .o_CLK        (o_CLK)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got,
                     input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s got=%0d want=%0d t=%0t",
                  tag, got, exp, $time);
  endtask

  function automatic void model_reset();
    m_elapsed = 0;
    m_clk = 1'b0;
    m_q = 0;
  endfunction

  // One CLK edge: the phase ends after H cycles in it.
  function automatic void model_edge();
    int  h;
    bit  rise;
    h = half_tab[contral];
    rise = 1'b0;
    m_elapsed = m_elapsed + 1;
    if (m_elapsed >= h) begin
      m_elapsed = 0;
      rise = !m_clk;
      m_clk = !m_clk;
    end
    if (load_enable)
      m_q = (load_counter <= 9) ? int'(load_counter) : 0;
    else if (rise)
      m_q = (m_q + 1) % 10;
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("q", oQ, m_q);
    chk("oclk", o_CLK, m_clk);
    chk("seg", odisplay, seg_tab[m_q]);
  endtask

  task automatic measure(input logic [1:0] sel);
    int h, n, hi, q0;
    bit ok;
    contral = sel;
    h = half_tab[sel];
    ok = 1'b0;
    for (int i = 0; i < 2 * h + 4; i++) begin
      logic p;
      p = o_CLK;
      cycle();
      if (!p && o_CLK) begin ok = 1'b1; break; end
    end
    chk("first_rise", ok, 1);
    q0 = oQ;
    for (int k = 0; k < 3; k++) begin
      n = 0; hi = 0; ok = 1'b0;
      while (n < 2 * h + 4) begin
        logic p;
        p = o_CLK;
        if (p) hi++;
        cycle();
        n++;
        if (!p && o_CLK) begin ok = 1'b1; break; end
      end
      chk("period", n, 2 * h);
      chk("duty", hi, h);
      chk("per_step", oQ, (q0 + k + 1) % 10);
    end
  endtask

  initial begin
    int seq [$];
    logic prev;
    int last;

    #3;
    chk("rst_q", oQ, 0);
    chk("rst_oclk", o_CLK, 0);
    chk("rst_seg", odisplay, 7'b1000000);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Count up under /2 to 5, then async reset mid-cycle.
    for (int i = 0; i < 30 && m_q != 5; i++) cycle();
    chk("reach5", oQ, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_q", oQ, 0);
    chk("arst_oclk", o_CLK, 0);
    chk("arst_seg", odisplay, 7'b1000000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    chk("post_rst_q", oQ, 3);

    // Held load.
    load_enable = 1'b1;
    load_counter = 4'd1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("hold_load", oQ, 1);
      chk("hold_seg", odisplay, 7'b1111001);
    end
    load_counter = 4'd12;
    cycle();
    chk("load_oor", oQ, 0);

    // Wrap 7 -> 8,9,0,1.
    load_counter = 4'd7;
    cycle();
    load_enable = 1'b0;
    last = oQ;
    for (int i = 0; i < 20 && seq.size() < 4; i++) begin
      cycle();
      if (int'(oQ) != last) begin
        seq.push_back(int'(oQ));
        last = oQ;
      end
    end
    chk("wrap_n", seq.size(), 4);
    if (seq.size() == 4) begin
      chk("wrap0", seq[0], 8);
      chk("wrap1", seq[1], 9);
      chk("wrap2", seq[2], 0);
      chk("wrap3", seq[3], 1);
    end

    // Load/tick collision: tick occurs while o_CLK is low.
    if (o_CLK) cycle();
    load_enable = 1'b1;
    load_counter = 4'd4;
    cycle();
    chk("coll_load", oQ, 4);
    load_enable = 1'b0;
    cycle();
    cycle();
    chk("coll_next", oQ, 5);

    // Division ratios.
    measure(2'd1);
    measure(2'd2);
    measure(2'd3);

    // Ratio drop mid-count.
    contral = 2'd2;
    for (int i = 0; i < 200 && m_elapsed != 40; i++) cycle();
    chk("at40", m_elapsed, 40);
    contral = 2'd1;
    prev = o_CLK;
    cycle();
    chk("sw_toggle", o_CLK, !prev);
    prev = o_CLK;
    for (int i = 0; i < 4; i++) cycle();
    chk("sw_hold", o_CLK, prev);
    cycle();
    chk("sw_next", o_CLK, !prev);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      contral = (r < 55) ? 2'd0 : (r < 90) ? 2'd1 :
                (r < 98) ? 2'd2 : 2'd3;
      load_enable = ($urandom_range(0, 9) == 0);
      load_counter = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
